// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button conditioner.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEATING    = 3'd3,
    RELEASE_WAIT = 3'd4
  } key_state_t;

  localparam int DEF_N_KEYS          = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Counter width for a terminal count; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bus between the raw buttons / enables and the conditioned event outputs.
interface key_conditioner_if
  import key_pkg::*;
#(
  parameter int N_KEYS = DEF_N_KEYS
);
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] repeat_en;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic [N_KEYS-1:0] repeat_pulse;

  modport master (
    output KEY, repeat_en,
    input  key_level, press_pulse, release_pulse, repeat_pulse
  );

  modport slave (
    input  KEY, repeat_en,
    output key_level, press_pulse, release_pulse, repeat_pulse
  );
endinterface

// File: rtl/key_channel.sv
// One key: two-flop synchronizer, debounce FSM, hold/repeat counters, registered events.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  input  logic repeat_en,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);
  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(REPEAT_DELAY);
  localparam int PW = cnt_width(REPEAT_PERIOD);
  // The detecting edge in IDLE/HELD is the first stable sample, so the last one is D-2.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(REPEAT_PERIOD - 1);

  logic [1:0]    sync_r;
  key_state_t    state_r, state_s;
  logic [DW-1:0] deb_cnt_r, deb_cnt_s;
  logic [HW-1:0] hold_cnt_r, hold_cnt_s;
  logic [PW-1:0] per_cnt_r, per_cnt_s;
  logic          from_rep_r, from_rep_s;
  logic          level_r, press_r, release_r, repeat_r;
  logic          press_s, release_s, repeat_s;
  logic          pressed_s, hold_mode_s, repeat_mode_s;

  assign pressed_s     = ~sync_r[1];
  assign hold_mode_s   = (state_r == HELD) || ((state_r == RELEASE_WAIT) && !from_rep_r);
  assign repeat_mode_s = (state_r == REPEATING) || ((state_r == RELEASE_WAIT) && from_rep_r);

  // Next-state and event decode; hold/period counters keep running through a release bounce.
  always_comb begin
    state_s    = state_r;
    deb_cnt_s  = deb_cnt_r;
    from_rep_s = from_rep_r;
    press_s    = 1'b0;
    release_s  = 1'b0;
    repeat_s   = 1'b0;
    if (hold_mode_s && (hold_cnt_r != HOLD_LAST)) begin
      hold_cnt_s = hold_cnt_r + HW'(1);
    end else begin
      hold_cnt_s = hold_cnt_r;
    end
    if (repeat_mode_s) begin
      per_cnt_s = (per_cnt_r == PER_LAST) ? '0 : per_cnt_r + PW'(1);
      repeat_s  = (per_cnt_r == PER_LAST) && repeat_en;
    end else begin
      per_cnt_s = per_cnt_r;
    end
    case (state_r)
      IDLE: begin
        if (pressed_s) begin
          state_s   = PRESS_WAIT;
          deb_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_s = IDLE;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_s    = HELD;
          press_s    = 1'b1;
          hold_cnt_s = '0;
          from_rep_s = 1'b0;
        end else begin
          deb_cnt_s = deb_cnt_r + DW'(1);
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_s    = RELEASE_WAIT;
          deb_cnt_s  = '0;
          from_rep_s = 1'b0;
        end else if (repeat_en && (hold_cnt_r == HOLD_LAST)) begin
          state_s   = REPEATING;
          repeat_s  = 1'b1;
          per_cnt_s = '0;
        end else begin
          state_s = HELD;
        end
      end
      REPEATING: begin
        if (!pressed_s) begin
          state_s    = RELEASE_WAIT;
          deb_cnt_s  = '0;
          from_rep_s = 1'b1;
        end else begin
          state_s = REPEATING;
        end
      end
      RELEASE_WAIT: begin
        if (pressed_s) begin
          state_s = from_rep_r ? REPEATING : HELD;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_s    = IDLE;
          release_s  = 1'b1;
          repeat_s   = 1'b0;
          hold_cnt_s = '0;
          per_cnt_s  = '0;
          from_rep_s = 1'b0;
        end else begin
          deb_cnt_s = deb_cnt_r + DW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_r     <= 2'b11;
      state_r    <= IDLE;
      deb_cnt_r  <= '0;
      hold_cnt_r <= '0;
      per_cnt_r  <= '0;
      from_rep_r <= 1'b0;
      level_r    <= 1'b0;
      press_r    <= 1'b0;
      release_r  <= 1'b0;
      repeat_r   <= 1'b0;
    end else begin
      sync_r     <= {sync_r[0], key_raw};
      state_r    <= state_s;
      deb_cnt_r  <= deb_cnt_s;
      hold_cnt_r <= hold_cnt_s;
      per_cnt_r  <= per_cnt_s;
      from_rep_r <= from_rep_s;
      level_r    <= (state_s == HELD) || (state_s == REPEATING) || (state_s == RELEASE_WAIT);
      press_r    <= press_s;
      release_r  <= release_s;
      repeat_r   <= repeat_s;
    end
  end

  assign key_level     = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/key_conditioner.sv
// Top level: one independent key_channel per push button on the key bus.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS          = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic               clk,
  input logic               reset_n,
  key_conditioner_if.slave  bus
);
  logic [N_KEYS-1:0] level_s, press_s, release_s, repeat_s;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_raw       (bus.KEY[i]),
      .repeat_en     (bus.repeat_en[i]),
      .key_level     (level_s[i]),
      .press_pulse   (press_s[i]),
      .release_pulse (release_s[i]),
      .repeat_pulse  (repeat_s[i])
    );
  end

  assign bus.key_level     = level_s;
  assign bus.press_pulse   = press_s;
  assign bus.release_pulse = release_s;
  assign bus.repeat_pulse  = repeat_s;

endmodule
